// File: rtl/btb_pkg.sv
// Shared types and constants for the branch target buffer.
// Latency: n/a (types, constants and a pure next-state function only).
// Backpressure: n/a.
package btb_pkg;

    // Entry fields are sized to the widest supported PC so the struct is
    // parameter-independent; narrower PCs are zero-extended on write.
    localparam int BTB_MAX_W = 64;

    localparam logic [1:0] BTB_SNT         = 2'b00;
    localparam logic [1:0] BTB_WNT         = 2'b01;
    localparam logic [1:0] BTB_ST          = 2'b10;
    localparam logic [1:0] BTB_WT          = 2'b11;
    localparam logic [1:0] BTB_ALLOC_STATE = BTB_ST;

    typedef struct packed {
        logic                 valid;
        logic [BTB_MAX_W-1:0] tag;
        logic [BTB_MAX_W-1:0] target;
        logic [1:0]           state;
    } btb_entry_t;

    // Direction state machine; state[1] is the current taken prediction.
    function automatic logic [1:0] btb_next_state(input logic [1:0] st, input logic taken);
        logic       mis;
        logic [1:0] nxt;
        mis = (st[1] != taken);
        case (st)
            BTB_SNT: nxt = mis ? BTB_WNT : BTB_SNT;
            BTB_WNT: nxt = mis ? BTB_ST  : BTB_SNT;
            BTB_ST:  nxt = mis ? BTB_WT  : BTB_ST;
            default: nxt = mis ? BTB_SNT : BTB_ST;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/btb_entry_array.sv
// BTB storage: two combinational read ports (lookup, update RMW), one write port, flush-all.
// Latency: reads are combinational; writes land at the clock edge.
// Backpressure: none; flush takes priority over a write in the same cycle.
module btb_entry_array
    import btb_pkg::*;
#(
    parameter int ENTRIES = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic [$clog2(ENTRIES)-1:0] lkp_idx,
    output btb_entry_t                 lkp_entry,
    input  logic [$clog2(ENTRIES)-1:0] upd_idx,
    output btb_entry_t                 upd_entry,
    input  logic                       wr_en,
    input  btb_entry_t                 wr_entry
);

    btb_entry_t mem_q [ENTRIES];
    btb_entry_t mem_d [ENTRIES];

    assign lkp_entry = mem_q[lkp_idx];
    assign upd_entry = mem_q[upd_idx];

    // Next array contents: flush clears only valid bits; otherwise apply the write.
    always_comb begin
        mem_d = mem_q;
        if (flush) begin
            for (int i = 0; i < ENTRIES; i++) begin
                mem_d[i].valid = 1'b0;
            end
        end else if (wr_en) begin
            mem_d[upd_idx] = wr_entry;
        end
    end

    // Entry storage with asynchronous clear of every field.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with 2-bit direction counters; optional BTB_BYPASS_EN forwards same-cycle updates to lookups.
// Latency: lookup in cycle N -> pred_* in N+1; update written at end of N, mispredict flag in N+1.
// Backpressure: none; accepts one lookup and one update every cycle.
module branch_target_buffer
    import btb_pkg::*;
#(
    parameter int ENTRIES  = 16,
    parameter int PC_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                lookup_valid,
    input  logic [PC_WIDTH-1:0] lookup_pc,
    output logic                pred_valid,
    output logic                pred_hit,
    output logic                pred_taken,
    output logic [PC_WIDTH-1:0] pred_target,
    input  logic                update_valid,
    input  logic [PC_WIDTH-1:0] update_pc,
    input  logic                update_taken,
    input  logic [PC_WIDTH-1:0] update_target,
    output logic                update_mispredict
);

    localparam int IDX_W = $clog2(ENTRIES);

    logic [IDX_W-1:0]     lkp_idx, upd_idx;
    logic [BTB_MAX_W-1:0] lkp_tag, upd_tag;
    btb_entry_t           lkp_rd, upd_rd, wr_entry, lkp_ent;
    logic                 wr_en, upd_hit, upd_mis, lkp_hit;

    logic                pred_valid_d, pred_valid_q;
    logic                pred_hit_d, pred_hit_q;
    logic                pred_taken_d, pred_taken_q;
    logic [PC_WIDTH-1:0] pred_target_d, pred_target_q;
    logic                mispredict_d, mispredict_q;

    // Word-aligned PCs: bits [1:0] never reach index or tag.
    assign lkp_idx = lookup_pc[IDX_W+1:2];
    assign upd_idx = update_pc[IDX_W+1:2];
    assign lkp_tag = BTB_MAX_W'(lookup_pc) >> (IDX_W + 2);
    assign upd_tag = BTB_MAX_W'(update_pc) >> (IDX_W + 2);

    btb_entry_array #(.ENTRIES(ENTRIES)) u_array (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .lkp_idx   (lkp_idx),
        .lkp_entry (lkp_rd),
        .upd_idx   (upd_idx),
        .upd_entry (upd_rd),
        .wr_en     (wr_en),
        .wr_entry  (wr_entry)
    );

    // Update path: train on hit, allocate on taken miss, drop when flushed.
    always_comb begin
        upd_hit  = upd_rd.valid && (upd_rd.tag == upd_tag);
        upd_mis  = (upd_rd.state[1] != update_taken);
        wr_en    = update_valid && !flush && (upd_hit || update_taken);
        wr_entry = upd_rd;
        if (upd_hit) begin
            wr_entry.state = btb_next_state(upd_rd.state, update_taken);
            if (update_taken) begin
                wr_entry.target = BTB_MAX_W'(update_target);
            end
        end else begin
            wr_entry.valid  = 1'b1;
            wr_entry.tag    = upd_tag;
            wr_entry.target = BTB_MAX_W'(update_target);
            wr_entry.state  = BTB_ALLOC_STATE;
        end
        // A miss is treated as a not-taken prediction; a dropped update reports nothing.
        mispredict_d = update_valid && !flush && (upd_hit ? upd_mis : update_taken);
    end

    // Lookup path: tag compare on the (optionally forwarded) entry.
    always_comb begin
        lkp_ent = lkp_rd;
`ifdef BTB_BYPASS_EN
        if (wr_en && (upd_idx == lkp_idx)) begin
            lkp_ent = wr_entry;
        end
`endif
        lkp_hit       = lookup_valid && !flush && lkp_ent.valid && (lkp_ent.tag == lkp_tag);
        pred_valid_d  = lookup_valid;
        pred_hit_d    = lkp_hit;
        pred_taken_d  = lkp_hit && lkp_ent.state[1];
        pred_target_d = lkp_hit ? PC_WIDTH'(lkp_ent.target) : '0;
    end

    // Output registers; reset discards any in-flight response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_valid_q  <= 1'b0;
            pred_hit_q    <= 1'b0;
            pred_taken_q  <= 1'b0;
            pred_target_q <= '0;
            mispredict_q  <= 1'b0;
        end else begin
            pred_valid_q  <= pred_valid_d;
            pred_hit_q    <= pred_hit_d;
            pred_taken_q  <= pred_taken_d;
            pred_target_q <= pred_target_d;
            mispredict_q  <= mispredict_d;
        end
    end

    assign pred_valid        = pred_valid_q;
    assign pred_hit          = pred_hit_q;
    assign pred_taken        = pred_taken_q;
    assign pred_target       = pred_target_q;
    assign update_mispredict = mispredict_q;

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed bench for branch_target_buffer with a queue-based scoreboard.
// Stimulus pushes hand-computed expectations; a negedge monitor pops and compares.
// ENTRIES=16: 0x100 -> idx 0 tag 4, 0x140 -> idx 0 tag 5, 0x108 -> idx 2, 0x10C -> idx 3.
module tb_branch_target_buffer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        lookup_valid = 1'b0;
    logic [31:0] lookup_pc = '0;
    logic        pred_valid, pred_hit, pred_taken;
    logic [31:0] pred_target;
    logic        update_valid = 1'b0;
    logic [31:0] update_pc = '0;
    logic        update_taken = 1'b0;
    logic [31:0] update_target = '0;
    logic        update_mispredict;

    typedef struct {
        logic        hit;
        logic        taken;
        logic [31:0] tgt;
    } exp_t;

    exp_t pred_q[$];
    logic mis_q[$];
    int   checks = 0;
    int   errors = 0;

    localparam logic BYP =
`ifdef BTB_BYPASS_EN
        1'b1;
`else
        1'b0;
`endif

    branch_target_buffer #(.ENTRIES(16), .PC_WIDTH(32)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .flush             (flush),
        .lookup_valid      (lookup_valid),
        .lookup_pc         (lookup_pc),
        .pred_valid        (pred_valid),
        .pred_hit          (pred_hit),
        .pred_taken        (pred_taken),
        .pred_target       (pred_target),
        .update_valid      (update_valid),
        .update_pc         (update_pc),
        .update_taken      (update_taken),
        .update_target     (update_target),
        .update_mispredict (update_mispredict)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus; expectations are queued once the edge has sampled it.
    task automatic step(input logic lv, input logic [31:0] lpc,
                        input logic uv, input logic [31:0] upc, input logic ut, input logic [31:0] utg,
                        input logic fl,
                        input logic eh, input logic et, input logic [31:0] etg, input logic em);
        lookup_valid  = lv;
        lookup_pc     = lpc;
        update_valid  = uv;
        update_pc     = upc;
        update_taken  = ut;
        update_target = utg;
        flush         = fl;
        @(posedge clk);
        if (lv) pred_q.push_back('{eh, et, etg});
        mis_q.push_back(em);
        #1;
        lookup_valid = 1'b0;
        update_valid = 1'b0;
        flush        = 1'b0;
    endtask

    task automatic lkp(input logic [31:0] pc, input logic eh, input logic et, input logic [31:0] etg);
        step(1'b1, pc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, eh, et, etg, 1'b0);
    endtask

    task automatic upd(input logic [31:0] pc, input logic ut, input logic [31:0] utg, input logic em);
        step(1'b0, 32'h0, 1'b1, pc, ut, utg, 1'b0, 1'b0, 1'b0, 32'h0, em);
    endtask

    // Monitor: compare responses against the scoreboard queues.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (pred_valid) begin
                    if (pred_q.size() == 0) begin
                        chk("pred_unexpected", 32'd1, 32'd0);
                    end else begin
                        e = pred_q.pop_front();
                        chk("pred_hit", {31'd0, pred_hit}, {31'd0, e.hit});
                        chk("pred_taken", {31'd0, pred_taken}, {31'd0, e.taken});
                        chk("pred_target", pred_target, e.tgt);
                    end
                end else begin
                    chk("idle_outputs_zero", {30'd0, pred_hit, pred_taken} | pred_target, 32'd0);
                end
                if (mis_q.size() != 0) begin
                    chk("update_mispredict", {31'd0, update_mispredict}, {31'd0, mis_q.pop_front()});
                end
            end
        end
    end

    initial begin
        #12 rst_n = 1'b1;
        #1;
        chk("rst_pred_valid", {31'd0, pred_valid}, 32'd0);
        chk("rst_pred_hit", {31'd0, pred_hit}, 32'd0);
        chk("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
        chk("rst_pred_target", pred_target, 32'd0);
        chk("rst_mispredict", {31'd0, update_mispredict}, 32'd0);

        lkp(32'h100, 1'b0, 1'b0, 32'h0);               // cold miss
        upd(32'h100, 1'b1, 32'h200, 1'b1);             // allocate, state ST
        lkp(32'h100, 1'b1, 1'b1, 32'h200);
        upd(32'h100, 1'b0, 32'h0, 1'b1);               // ST -> WT
        upd(32'h100, 1'b0, 32'h0, 1'b1);               // WT -> SNT
        upd(32'h100, 1'b0, 32'h0, 1'b0);               // SNT -> SNT
        upd(32'h100, 1'b0, 32'h0, 1'b0);               // SNT -> SNT
        lkp(32'h100, 1'b1, 1'b0, 32'h200);             // target kept on not-taken
        upd(32'h100, 1'b1, 32'h300, 1'b1);             // SNT -> WNT, target 0x300
        lkp(32'h100, 1'b1, 1'b0, 32'h300);
        upd(32'h100, 1'b1, 32'h300, 1'b1);             // WNT -> ST
        lkp(32'h100, 1'b1, 1'b1, 32'h300);
        upd(32'h140, 1'b1, 32'h400, 1'b1);             // alias replaces idx 0
        lkp(32'h100, 1'b0, 1'b0, 32'h0);
        lkp(32'h140, 1'b1, 1'b1, 32'h400);

        // Same-cycle lookup and allocating update on a fresh index.
        step(1'b1, 32'h108, 1'b1, 32'h108, 1'b1, 32'h500, 1'b0,
             BYP, BYP, BYP ? 32'h500 : 32'h0, 1'b1);
        lkp(32'h108, 1'b1, 1'b1, 32'h500);

        // Flush with an update: update dropped, all entries invalidated.
        step(1'b0, 32'h0, 1'b1, 32'h10C, 1'b1, 32'h600, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        lkp(32'h10C, 1'b0, 1'b0, 32'h0);
        lkp(32'h108, 1'b0, 1'b0, 32'h0);
        lkp(32'h140, 1'b0, 1'b0, 32'h0);

        // Flush with a lookup in the same cycle reports a miss.
        upd(32'h108, 1'b1, 32'h700, 1'b1);
        step(1'b1, 32'h108, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        lkp(32'h108, 1'b0, 1'b0, 32'h0);

        // Get outputs non-zero, then reset asynchronously mid-lookup.
        upd(32'h100, 1'b1, 32'h800, 1'b1);
        lkp(32'h100, 1'b1, 1'b1, 32'h800);
        @(negedge clk);
        #1;
        lookup_valid = 1'b1;
        lookup_pc    = 32'h100;
        #1 rst_n = 1'b0;
        #1;
        chk("arst_pred_valid", {31'd0, pred_valid}, 32'd0);
        chk("arst_pred_hit", {31'd0, pred_hit}, 32'd0);
        chk("arst_pred_taken", {31'd0, pred_taken}, 32'd0);
        chk("arst_pred_target", pred_target, 32'd0);
        chk("arst_mispredict", {31'd0, update_mispredict}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("arst_hold_pred_valid", {31'd0, pred_valid}, 32'd0);
        lookup_valid = 1'b0;
        rst_n = 1'b1;
        lkp(32'h100, 1'b0, 1'b0, 32'h0);
        lkp(32'h108, 1'b0, 1'b0, 32'h0);

        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        #1;
        chk("pred_queue_drained", pred_q.size(), 32'd0);
        chk("mis_queue_drained", mis_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
